// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-image loader and future DMA/fetch blocks.
package mem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned STATE_W    = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD   = 3'd1;
  localparam state_t S_WRITE  = 3'd2;
  localparam state_t S_VERIFY = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  // Byte address of word idx relative to base; wraps silently at 2^32.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] idx);
    return base + (idx << $clog2(WORD_BYTES));
  endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Assembles little-endian words from a byte stream; first byte lands in [7:0].
module mem_loader_byte_packer
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  localparam int unsigned BCNT_W = $clog2(WORD_BYTES);

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [WORD_W-1:0] word_q, word_d;

  // word_c already carries the byte offered this cycle so the last lane is usable at once.
  always_comb begin
    word_c                              = word_q;
    word_c[bcnt_q*BYTE_W +: BYTE_W]     = byte_i;
    word_valid_c = byte_en_i && (bcnt_q == BCNT_W'(WORD_BYTES - 1));
    bcnt_d       = bcnt_q;
    word_d       = word_q;
    if (clr_i) begin
      bcnt_d = '0;
      word_d = '0;
    end else if (byte_en_i) begin
      bcnt_d = bcnt_q + BCNT_W'(1);
      word_d = word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
      word_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Boot-image loader: streams bytes into memory as words, then re-reads and
// checks an additive checksum before signalling done/err.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       MAX_WORDS = 1024,
  parameter int unsigned       LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_data_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  widx_q, widx_d;
  logic [LEN_W-1:0]  vidx_q, vidx_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic [WORD_W-1:0] vsum_q, vsum_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              len_zero;
  logic              len_over;
  logic              pk_clr;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic [LEN_W-1:0]  widx_inc;
  logic [LEN_W-1:0]  vidx_inc;
  logic [WORD_W-1:0] vsum_next;

  assign in_ready  = (state_q == S_LOAD);
  assign xfer      = in_valid && in_ready;
  assign len_zero  = (len_words == '0);
  assign len_over  = 32'(len_words) > MAX_WORDS;
  assign widx_inc  = widx_q + LEN_W'(1);
  assign vidx_inc  = vidx_q + LEN_W'(1);
  assign vsum_next = vsum_q + mem_data_out;

  mem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (pk_clr),
    .byte_en_i    (xfer),
    .byte_i       (in_data),
    .word_c       (word),
    .word_valid_c (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      widx_q        <= '0;
      vidx_q        <= '0;
      sum_q         <= '0;
      vsum_q        <= '0;
      mem_addr_q    <= BASE_ADDR;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      widx_q        <= widx_d;
      vidx_q        <= vidx_d;
      sum_q         <= sum_d;
      vsum_q        <= vsum_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_we_q      <= mem_we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (len_zero || len_over) ? S_DONE : S_LOAD;
      end
      S_LOAD:   if (word_valid) state_d = S_WRITE;
      S_WRITE:  state_d = (widx_inc == len_q) ? S_VERIFY : S_LOAD;
      S_VERIFY: if (vidx_inc == len_q) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed for the state being entered.
  always_comb begin
    len_d         = len_q;
    widx_d        = widx_q;
    vidx_d        = vidx_q;
    sum_d         = sum_q;
    vsum_d        = vsum_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    err_d         = err_q;
    pk_clr        = 1'b0;
    mem_we_d      = (state_d == S_WRITE);
    busy_d        = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_VERIFY);
    done_d        = (state_d == S_DONE);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d = len_over;
          if (!len_zero && !len_over) begin
            len_d  = len_words;
            widx_d = '0;
            vidx_d = '0;
            sum_d  = '0;
            vsum_d = '0;
            pk_clr = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (word_valid) begin
          mem_addr_d    = word_addr(BASE_ADDR, 32'(widx_q));
          mem_data_in_d = word;
        end
      end
      S_WRITE: begin
        sum_d  = sum_q + mem_data_in_q;
        widx_d = widx_inc;
        if (state_d == S_VERIFY) mem_addr_d = word_addr(BASE_ADDR, 32'(vidx_q));
      end
      S_VERIFY: begin
        vsum_d = vsum_next;
        vidx_d = vidx_inc;
        if (state_d == S_DONE) err_d = (vsum_next != sum_q);
        else                   mem_addr_d = word_addr(BASE_ADDR, 32'(vidx_inc));
      end
      default: ;
    endcase
  end

  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_we      = mem_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboarded bench for mem_loader driving a behavioural word memory.
module tb_mem_loader;

  typedef logic [31:0] wq_t[$];
  typedef logic [7:0]  bq_t[$];

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, mem_we, busy, done, err;
  logic [15:0] len_words;
  logic [7:0]  in_data;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;

  always #1 clk = ~clk;

  mem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len_words    (len_words),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // Word memory; poke port lets the bench corrupt/preset words on a clock edge.
  logic [31:0] mem [0:4095];
  logic        poke_en;
  logic [11:0] poke_idx;
  logic [31:0] poke_val;
  always @(posedge clk) begin
    if (mem_we)  mem[mem_addr[13:2]] <= mem_data_in;
    if (poke_en) mem[poke_idx]       <= poke_val;
  end
  assign mem_data_out = mem[mem_addr[13:2]];

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_wr_q[$];
  logic        exp_done_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: little-endian byte packing and additive checksum comparison.
  function automatic logic [31:0] word_of(input bq_t b, input int i);
    return 32'(b[4*i]) + 32'(b[4*i+1]) * 32'd256 + 32'(b[4*i+2]) * 32'd65536
         + 32'(b[4*i+3]) * 32'd16777216;
  endfunction

  function automatic wq_t words_of(input bq_t b, input int len);
    wq_t w;
    for (int i = 0; i < len; i++) w.push_back(word_of(b, i));
    return w;
  endfunction

  function automatic logic model_err(input wq_t written, input wq_t readback);
    logic [31:0] s1, s2;
    s1 = 0;
    s2 = 0;
    foreach (written[i])  s1 += written[i];
    foreach (readback[i]) s2 += readback[i];
    return s1 != s2;
  endfunction

  task automatic expect_writes(input wq_t w);
    foreach (w[i]) exp_wr_q.push_back({32'(i) * 32'd4, w[i]});
  endtask

  // Monitor: every write and every completion is popped from the scoreboard.
  logic start_seen = 1'b0;
  logic done_prev  = 1'b0;
  always @(posedge clk) start_seen <= start;

  always @(negedge clk) begin
    logic [63:0] e;
    logic        ee;
    if (mem_we) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %08h data %08h expected no write", mem_addr, mem_data_in);
      end else begin
        e = exp_wr_q.pop_front();
        check32("wr_addr", mem_addr, e[63:32]);
        check32("wr_data", mem_data_in, e[31:0]);
      end
    end
    if (done && (!done_prev || start_seen)) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done err=%0b expected no completion", err);
      end else begin
        ee = exp_done_q.pop_front();
        check32("done_err", 32'(err), 32'(ee));
      end
    end
    done_prev = done;
  end

  task automatic pulse_start(input int len);
    start     = 1'b1;
    len_words = 16'(len);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got in_ready=0 after %0d cycles expected 1", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: got done=0 after %0d cycles expected 1", n);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    poke_en  = 1'b1;
    poke_idx = 12'(idx);
    poke_val = val;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  task automatic gap(input int cycles);
    in_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check32("gap_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  bq_t img;
  bq_t rb;
  wq_t w;
  wq_t wbad;
  int  len;
  int  n;

  initial begin
    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rst = 1'b1; start = 1'b0; len_words = '0; in_valid = 1'b0; in_data = '0;
    poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    repeat (3) @(negedge clk);
    check32("rst_in_ready", 32'(in_ready), 32'd0);
    check32("rst_we", 32'(mem_we), 32'd0);
    check32("rst_addr", mem_addr, 32'h0);
    check32("rst_data", mem_data_in, 32'h0);
    check32("rst_flags", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-word image, back-to-back bytes.
    w = words_of(img, 2);
    expect_writes(w);
    exp_done_q.push_back(model_err(w, w));
    pulse_start(2);
    check32("t1_busy", 32'(busy), 32'd1);
    foreach (img[i]) send_byte(img[i]);
    wait_done(50);
    check32("t1_mem0", mem[0], 32'h1234_5678);
    check32("t1_mem1", mem[1], 32'hDEAD_BEEF);
    check32("t1_err", 32'(err), 32'd0);

    // Same image with a 5-cycle valid gap after byte 2.
    poke(0, 32'h0);
    poke(1, 32'h0);
    expect_writes(w);
    exp_done_q.push_back(model_err(w, w));
    pulse_start(2);
    foreach (img[i]) begin
      if (i == 2) gap(5);
      send_byte(img[i]);
    end
    wait_done(50);
    check32("t2_mem0", mem[0], 32'h1234_5678);
    check32("t2_mem1", mem[1], 32'hDEAD_BEEF);

    // Zero and over-limit lengths finish immediately without writes.
    exp_done_q.push_back(1'b0);
    pulse_start(0);
    check32("t3_zero_done", 32'(done), 32'd1);
    check32("t3_zero_err", 32'(err), 32'd0);
    exp_done_q.push_back(1'b1);
    pulse_start(1025);
    check32("t3_over_done", 32'(done), 32'd1);
    check32("t3_over_err", 32'(err), 32'd1);
    @(negedge clk);

    // Corrupt word 1 after it is written but before it is re-read.
    wbad = '{32'h1234_5678, 32'h0};
    expect_writes(w);
    exp_done_q.push_back(model_err(w, wbad));
    pulse_start(2);
    foreach (img[i]) send_byte(img[i]);
    n = 0;
    while (!(mem_we && mem_addr == 32'd4) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    poke(1, 32'h0);
    wait_done(50);
    check32("t4_err", 32'(err), 32'd1);

    // Reset after six bytes: partial word dropped, first word kept.
    poke(1, 32'hA5A5_A5A5);
    exp_wr_q.push_back({32'd0, w[0]});
    pulse_start(2);
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check32("t5_idle", {28'd0, busy, done, mem_we, in_ready}, 32'd0);
    @(negedge clk);
    check32("t5_mem0", mem[0], 32'h1234_5678);
    check32("t5_mem1", mem[1], 32'hA5A5_A5A5);
    rb = '{8'h11, 8'h22, 8'h33, 8'h44};
    wbad = words_of(rb, 1);
    expect_writes(wbad);
    exp_done_q.push_back(model_err(wbad, wbad));
    pulse_start(1);
    foreach (rb[i]) send_byte(rb[i]);
    wait_done(50);
    check32("t5_restart_mem0", mem[0], 32'h4433_2211);

    // Start during LOAD must be ignored.
    expect_writes(w);
    exp_done_q.push_back(model_err(w, w));
    pulse_start(2);
    foreach (img[i]) begin
      if (i == 3) pulse_start(7);
      send_byte(img[i]);
    end
    wait_done(50);
    check32("t6_mem0", mem[0], 32'h1234_5678);
    check32("t6_mem1", mem[1], 32'hDEAD_BEEF);

    // Randomised images with random stalls, plus occasional over-limit lengths.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        len = int'($urandom_range(1025, 65535));
        exp_done_q.push_back(1'b1);
        pulse_start(len);
        check32("rnd_over_err", 32'(err), 32'd1);
      end else begin
        len = int'($urandom_range(1, 8));
        rb.delete();
        for (int i = 0; i < 4 * len; i++) rb.push_back(8'($urandom));
        wbad = words_of(rb, len);
        expect_writes(wbad);
        exp_done_q.push_back(model_err(wbad, wbad));
        pulse_start(len);
        foreach (rb[i]) begin
          n = int'($urandom_range(0, 3));
          if (n != 0) gap(n);
          send_byte(rb[i]);
        end
        wait_done(400);
        for (int i = 0; i < len; i++) check32("rnd_mem", mem[i], wbad[i]);
      end
    end

    repeat (4) @(negedge clk);
    check32("sb_writes_left", 32'(exp_wr_q.size()), 32'd0);
    check32("sb_dones_left", 32'(exp_done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
